// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared types and constants for the instruction loader.
// LOADER_CHECKSUM_EN adds the trailing-checksum state.
package instr_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FINISH
    } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: big-endian 8->32 shift register with byte counter.
// LOADER_CHECKSUM_EN adds an XOR accumulator over packed bytes.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        csum
`endif
);

    logic [WORD_W-9:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    // Word as it stands once the byte currently offered lands.
    assign word       = {shift_q, data};
    assign word_valid = en && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in MSB-first; counter wraps after each word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            shift_q <= word[WORD_W-9:0];
            cnt_q   <= cnt_q + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of payload bytes for the trailing check byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (clr) begin
            csum <= '0;
        end else if (en) begin
            csum <= csum ^ data;
        end
    end
`endif

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte stream to big-endian instruction-word writes.
// LOADER_CHECKSUM_EN enables a trailing XOR checksum byte.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;

    loader_state_t     state_q;
    logic [7:0]        n_hi_q;
    logic [15:0]       n_words_q;
    logic [15:0]       n_full;
    logic [16:0]       wl_next;
    logic              fire;
    logic              last_word;
    logic              too_big;
    logic              pk_clr;
    logic              pk_en;
    logic [WORD_W-1:0] pk_word;
    logic              pk_word_valid;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        pk_csum;
`endif

    assign fire      = s_valid & s_ready;
    assign n_full    = {n_hi_q, s_data};
    assign wl_next   = 17'(words_loaded) + 17'd1;
    assign last_word = (wl_next == 17'(n_words_q));
    assign too_big   = (17'(n_full) > 17'(DEPTH));
    assign pk_clr    = (state_q == ST_IDLE) && start;
    assign pk_en     = fire && (state_q == ST_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .en         (pk_en),
        .data       (s_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
`ifdef LOADER_CHECKSUM_EN
        ,
        .csum       (pk_csum)
`endif
    );

    // Load sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            n_hi_q       <= '0;
            n_words_q    <= '0;
            s_ready      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        err          <= 1'b0;
                        words_loaded <= '0;
                        busy         <= 1'b1;
                        s_ready      <= 1'b1;
                        state_q      <= ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (fire) begin
                        n_hi_q  <= s_data;
                        state_q <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (fire) begin
                        n_words_q <= n_full;
                        if (too_big) begin
                            err     <= 1'b1;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= ST_FINISH;
                        end else if (n_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= ST_FINISH;
`endif
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (pk_word_valid) begin
                        mem_we       <= 1'b1;
                        mem_addr     <= words_loaded[ADDR_W-1:0];
                        mem_wdata    <= pk_word;
                        words_loaded <= wl_next[ADDR_W:0];
                        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= ST_FINISH;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (fire) begin
                        if (s_data != pk_csum) begin
                            err <= 1'b1;
                        end
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= ST_FINISH;
                    end
                end
`endif
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
